// File: rtl/ag32gbd_bus_capture_if.sv
// Cartridge bus as seen by the capture block, plus the decoded write-event
// outputs it produces. The capture block uses the slave view; whoever
// drives the cartridge pins and consumes the write events uses master.
interface ag32gbd_bus_capture_if;
    logic [15:0] Cart_a;
    logic [7:0]  Cart_d;
    logic        Cart_nWR;
    logic        wr_strobe;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic [1:0]  wr_region;
    logic        wr_timeout;

    modport slave (
        input  Cart_a, Cart_d, Cart_nWR,
        output wr_strobe, wr_addr, wr_data, wr_region, wr_timeout
    );

    modport master (
        output Cart_a, Cart_d, Cart_nWR,
        input  wr_strobe, wr_addr, wr_data, wr_region, wr_timeout
    );
endinterface

// File: rtl/ag32gbd_bus_capture.sv
// Captures cartridge write cycles from an asynchronous bus: synchronizes
// nWR/address/data together, debounces the strobe, and reports each
// completed write (or a stuck-low abort) as a one-cycle event.
module ag32gbd_bus_capture #(
    parameter int FILTER_LEN = 3,
    parameter int MAX_LOW    = 255
) (
    input  logic                    sys_clock,
    input  logic                    sys_reset,
    ag32gbd_bus_capture_if.slave    bus
);

    localparam int SYNC_STAGES = 2;
    localparam int SYNC_W      = 25;   // {nWR, addr[15:0], data[7:0]}
    localparam logic [SYNC_W-1:0] SYNC_RST = {1'b1, 24'h000000};

    localparam int CNT_W  = $clog2(MAX_LOW + 1);
    localparam int CNT_W1 = CNT_W + 1;
    localparam logic [CNT_W:0]   C_FILTER = CNT_W1'(FILTER_LEN);
    localparam logic [CNT_W:0]   C_MAX    = CNT_W1'(MAX_LOW);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MAX_LOW);

    typedef enum logic [2:0] {
        WAIT_HIGH,
        IDLE,
        FILTER,
        ARMED,
        STUCK
    } state_t;

    logic [SYNC_W-1:0] r_sync [SYNC_STAGES];
    logic [1:0]        r_prime;
    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [15:0]       r_pend_addr;
    logic [7:0]        r_pend_data;
    logic              r_commit;
    logic              r_abort;
    logic              r_wr_strobe;
    logic [15:0]       r_wr_addr;
    logic [7:0]        r_wr_data;
    logic [1:0]        r_wr_region;
    logic              r_wr_timeout;

    logic              w_nwr_s;
    logic [15:0]       w_a_s;
    logic [7:0]        w_d_s;
    logic              w_settled;
    logic [CNT_W:0]    w_cnt_inc;
    logic [1:0]        w_region;

    assign w_nwr_s   = r_sync[SYNC_STAGES-1][24];
    assign w_a_s     = r_sync[SYNC_STAGES-1][23:8];
    assign w_d_s     = r_sync[SYNC_STAGES-1][7:0];
    // The reset value of the nWR chain is "high"; it only reflects the pin
    // once every stage has been refilled after reset. Without this, a strobe
    // held low across reset release would look like a fresh falling edge.
    assign w_settled = r_prime[1];
    assign w_cnt_inc = {1'b0, r_cnt} + CNT_W1'(1);

    // Two-stage synchronizer; strobe, address and data share one chain so they stay aligned.
    always_ff @(posedge sys_clock) begin
        if (sys_reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= SYNC_RST;
        end else begin
            r_sync[0] <= {bus.Cart_nWR, bus.Cart_a, bus.Cart_d};
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    // Tracks how many post-reset cycles have refilled the synchronizer.
    always_ff @(posedge sys_clock) begin
        if (sys_reset) r_prime <= 2'b00;
        else           r_prime <= {r_prime[0], 1'b1};
    end

    // Write-qualification FSM: debounce, capture, commit or abort.
    always_ff @(posedge sys_clock) begin
        if (sys_reset) begin
            r_state     <= WAIT_HIGH;
            r_cnt       <= '0;
            r_pend_addr <= 16'h0000;
            r_pend_data <= 8'h00;
            r_commit    <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_commit <= 1'b0;
            r_abort  <= 1'b0;
            case (r_state)
                WAIT_HIGH, STUCK: begin
                    r_cnt <= '0;
                    if (w_settled && w_nwr_s) r_state <= IDLE;
                end
                IDLE: begin
                    if (!w_nwr_s) begin
                        r_cnt <= CNT_ONE;
                        if (C_FILTER == CNT_W1'(1)) begin
                            r_state     <= ARMED;
                            r_pend_addr <= w_a_s;
                            r_pend_data <= w_d_s;
                        end else begin
                            r_state <= FILTER;
                        end
                    end
                end
                FILTER: begin
                    if (w_nwr_s) begin
                        r_state <= IDLE;   // too short: glitch
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc[CNT_W-1:0];
                        if (w_cnt_inc == C_FILTER) begin
                            // Data is captured here too so a write exactly
                            // FILTER_LEN samples long still has valid data.
                            r_state     <= ARMED;
                            r_pend_addr <= w_a_s;
                            r_pend_data <= w_d_s;
                        end
                    end
                end
                ARMED: begin
                    if (w_nwr_s) begin
                        r_commit <= 1'b1;
                        r_state  <= IDLE;
                        r_cnt    <= '0;
                    end else begin
                        r_pend_data <= w_d_s;
                        if (w_cnt_inc >= C_MAX) begin
                            r_abort <= 1'b1;
                            r_state <= STUCK;
                            r_cnt   <= CNT_SAT;
                        end else begin
                            r_cnt <= w_cnt_inc[CNT_W-1:0];
                        end
                    end
                end
                default: begin
                    r_state <= WAIT_HIGH;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Region decode of the pending address.
    always_comb begin
        w_region = 2'd3;
        case (r_pend_addr[15:13])
            3'b000:         w_region = 2'd0;
            3'b001:         w_region = 2'd1;
            3'b010, 3'b011: w_region = 2'd2;
            default:        w_region = 2'd3;
        endcase
    end

    // Output register: publishes a committed write or a timeout for one cycle.
    always_ff @(posedge sys_clock) begin
        if (sys_reset) begin
            r_wr_strobe  <= 1'b0;
            r_wr_timeout <= 1'b0;
            r_wr_addr    <= 16'h0000;
            r_wr_data    <= 8'h00;
            r_wr_region  <= 2'd0;
        end else begin
            r_wr_strobe  <= r_commit;
            r_wr_timeout <= r_abort;
            if (r_commit) begin
                r_wr_addr   <= r_pend_addr;
                r_wr_data   <= r_pend_data;
                r_wr_region <= w_region;
            end
        end
    end

    assign bus.wr_strobe  = r_wr_strobe;
    assign bus.wr_timeout = r_wr_timeout;
    assign bus.wr_addr    = r_wr_addr;
    assign bus.wr_data    = r_wr_data;
    assign bus.wr_region  = r_wr_region;

endmodule

// File: tb/tb_ag32gbd_bus_capture.sv
// Directed bench for ag32gbd_bus_capture: a table of write cycles with
// hand-computed results plus hand-written reset/data-change/back-to-back cases.
module tb_ag32gbd_bus_capture;

    logic sys_clock = 1'b0;
    logic sys_reset;

    ag32gbd_bus_capture_if bus();

    ag32gbd_bus_capture #(
        .FILTER_LEN(3),
        .MAX_LOW   (255)
    ) dut (
        .sys_clock(sys_clock),
        .sys_reset(sys_reset),
        .bus      (bus)
    );

    always #5 sys_clock = ~sys_clock;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        int          low;
        int          high;
        int          exp_stb;
        int          exp_to;
        logic [15:0] exp_a;
        logic [7:0]  exp_d;
        logic [1:0]  exp_r;
    } vec_t;

    vec_t vecs[12];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_stb  = 0;
    int n_to   = 0;
    int last_stb_cyc = -1;
    logic [15:0] q_addr[$];
    logic [7:0]  q_data[$];
    int          q_cyc[$];

    always @(posedge sys_clock) cyc = cyc + 1;

    // Event monitor, sampled away from the active edge.
    always @(negedge sys_clock) begin
        if (bus.wr_strobe === 1'b1) begin
            n_stb = n_stb + 1;
            last_stb_cyc = cyc;
            q_addr.push_back(bus.wr_addr);
            q_data.push_back(bus.wr_data);
            q_cyc.push_back(cyc);
        end
        if (bus.wr_timeout === 1'b1) n_to = n_to + 1;
        if (bus.wr_strobe === 1'b1 || bus.wr_timeout === 1'b1) begin
            n_cmp = n_cmp + 1;
            if (bus.wr_strobe === 1'b1 && bus.wr_timeout === 1'b1) begin
                n_fail = n_fail + 1;
                $display("FAIL strobe_timeout_overlap: both high at cycle %0d, required not both", cyc);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [15:0] a, input logic [7:0] d,
                                 input logic [1:0] r);
        check({tag, "_addr"},   {16'h0, bus.wr_addr},    {16'h0, a});
        check({tag, "_data"},   {24'h0, bus.wr_data},    {24'h0, d});
        check({tag, "_region"}, {30'h0, bus.wr_region},  {30'h0, r});
    endtask

    // Drive one write: nWR low for 'low' edges, then high for 'high' edges.
    task automatic do_write(input logic [15:0] a, input logic [7:0] d,
                            input int low, input int high, output int rel);
        @(negedge sys_clock);
        bus.Cart_a   = a;
        bus.Cart_d   = d;
        bus.Cart_nWR = 1'b0;
        repeat (low) @(posedge sys_clock);
        @(negedge sys_clock);
        bus.Cart_nWR = 1'b1;
        rel = cyc + 1;
        repeat (high) @(posedge sys_clock);
    endtask

    initial begin
        int rel;
        int stb0;
        int to0;

        vecs[0]  = '{16'h2100, 8'h05, 10,  8, 1, 0, 16'h2100, 8'h05, 2'd1};
        vecs[1]  = '{16'h2000, 8'h1F, 2,   8, 0, 0, 16'h2100, 8'h05, 2'd1};
        vecs[2]  = '{16'h1234, 8'h77, 300, 8, 0, 1, 16'h2100, 8'h05, 2'd1};
        vecs[3]  = '{16'hA000, 8'h3C, 6,   8, 1, 0, 16'hA000, 8'h3C, 2'd3};
        vecs[4]  = '{16'h6123, 8'h99, 3,   8, 1, 0, 16'h6123, 8'h99, 2'd2};
        vecs[5]  = '{16'h1FFF, 8'hC3, 4,   8, 1, 0, 16'h1FFF, 8'hC3, 2'd0};
        vecs[6]  = '{16'h3FFF, 8'h5A, 5,   8, 1, 0, 16'h3FFF, 8'h5A, 2'd1};
        vecs[7]  = '{16'h7FFF, 8'hA5, 7,   8, 1, 0, 16'h7FFF, 8'hA5, 2'd2};
        vecs[8]  = '{16'h8000, 8'hFF, 8,   8, 1, 0, 16'h8000, 8'hFF, 2'd3};
        vecs[9]  = '{16'hC000, 8'hE1, 254, 8, 1, 0, 16'hC000, 8'hE1, 2'd3};
        vecs[10] = '{16'h0100, 8'h12, 255, 8, 0, 1, 16'hC000, 8'hE1, 2'd3};
        vecs[11] = '{16'h2000, 8'h1F, 1,   8, 0, 0, 16'hC000, 8'hE1, 2'd3};

        // Reset state
        bus.Cart_a   = 16'h0000;
        bus.Cart_d   = 8'h00;
        bus.Cart_nWR = 1'b1;
        sys_reset    = 1'b1;
        repeat (4) @(posedge sys_clock);
        @(negedge sys_clock);
        check("rst_strobe",  {31'h0, bus.wr_strobe},  32'h0);
        check("rst_timeout", {31'h0, bus.wr_timeout}, 32'h0);
        check_outputs("rst", 16'h0000, 8'h00, 2'd0);
        sys_reset = 1'b0;
        repeat (4) @(posedge sys_clock);

        // Table-driven writes
        for (int i = 0; i < 12; i++) begin
            stb0 = n_stb;
            to0  = n_to;
            do_write(vecs[i].a, vecs[i].d, vecs[i].low, vecs[i].high, rel);
            @(negedge sys_clock);
            #1;
            $display("vec %0d: a=%h d=%h low=%0d -> strobes=%0d timeouts=%0d wr_addr=%h wr_data=%h region=%0d",
                     i, vecs[i].a, vecs[i].d, vecs[i].low, n_stb - stb0, n_to - to0,
                     bus.wr_addr, bus.wr_data, bus.wr_region);
            check($sformatf("v%0d_strobes", i), n_stb - stb0, vecs[i].exp_stb);
            check($sformatf("v%0d_timeouts", i), n_to - to0, vecs[i].exp_to);
            check_outputs($sformatf("v%0d", i), vecs[i].exp_a, vecs[i].exp_d, vecs[i].exp_r);
            if (vecs[i].exp_stb == 1)
                check($sformatf("v%0d_latency", i), last_stb_cyc, rel + 3);
        end

        // Data changes mid-write, address disturbed while armed
        stb0 = n_stb;
        @(negedge sys_clock);
        bus.Cart_a   = 16'h4000;
        bus.Cart_d   = 8'h11;
        bus.Cart_nWR = 1'b0;
        repeat (3) @(posedge sys_clock);
        @(negedge sys_clock);
        bus.Cart_d = 8'h22;
        repeat (3) @(posedge sys_clock);
        @(negedge sys_clock);
        bus.Cart_a = 16'hE000;
        repeat (2) @(posedge sys_clock);
        @(negedge sys_clock);
        bus.Cart_nWR = 1'b1;
        repeat (8) @(posedge sys_clock);
        @(negedge sys_clock);
        #1;
        $display("datachg: strobes=%0d wr_addr=%h wr_data=%h region=%0d",
                 n_stb - stb0, bus.wr_addr, bus.wr_data, bus.wr_region);
        check("datachg_strobes", n_stb - stb0, 1);
        check_outputs("datachg", 16'h4000, 8'h22, 2'd2);

        // Reset while armed, released with nWR still low
        stb0 = n_stb;
        to0  = n_to;
        @(negedge sys_clock);
        bus.Cart_a   = 16'h3000;
        bus.Cart_d   = 8'h77;
        bus.Cart_nWR = 1'b0;
        repeat (6) @(posedge sys_clock);
        @(negedge sys_clock);
        sys_reset = 1'b1;
        repeat (3) @(posedge sys_clock);
        @(negedge sys_clock);
        check("midrst_strobe_during", {31'h0, bus.wr_strobe}, 32'h0);
        sys_reset = 1'b0;
        repeat (5) @(posedge sys_clock);
        @(negedge sys_clock);
        bus.Cart_nWR = 1'b1;
        repeat (10) @(posedge sys_clock);
        @(negedge sys_clock);
        #1;
        $display("midrst: strobes=%0d timeouts=%0d wr_addr=%h wr_data=%h",
                 n_stb - stb0, n_to - to0, bus.wr_addr, bus.wr_data);
        check("midrst_strobes", n_stb - stb0, 0);
        check("midrst_timeouts", n_to - to0, 0);
        check_outputs("midrst", 16'h0000, 8'h00, 2'd0);

        stb0 = n_stb;
        do_write(16'h0000, 8'h0A, 5, 8, rel);
        @(negedge sys_clock);
        #1;
        $display("postrst: strobes=%0d wr_addr=%h wr_data=%h region=%0d",
                 n_stb - stb0, bus.wr_addr, bus.wr_data, bus.wr_region);
        check("postrst_strobes", n_stb - stb0, 1);
        check("postrst_latency", last_stb_cyc, rel + 3);
        check_outputs("postrst", 16'h0000, 8'h0A, 2'd0);

        // Back-to-back writes
        q_addr.delete();
        q_data.delete();
        q_cyc.delete();
        do_write(16'h2001, 8'h01, 6, 6, rel);
        do_write(16'h2002, 8'h02, 6, 8, rel);
        @(negedge sys_clock);
        #1;
        $display("b2b: strobes=%0d", q_addr.size());
        check("b2b_count", q_addr.size(), 2);
        if (q_addr.size() == 2) begin
            check("b2b_addr0", {16'h0, q_addr[0]}, 32'h2001);
            check("b2b_data0", {24'h0, q_data[0]}, 32'h01);
            check("b2b_addr1", {16'h0, q_addr[1]}, 32'h2002);
            check("b2b_data1", {24'h0, q_data[1]}, 32'h02);
            check("b2b_spacing_ok", (q_cyc[1] - q_cyc[0]) >= 5, 1);
        end
        check_outputs("b2b_final", 16'h2002, 8'h02, 2'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
